// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single-ported synchronous memory.
// Each accepted request runs a fixed three-cycle sequence:
//   IDLE   : a request is accepted (reqN_ready pulses) and latched
//   ACCESS : the latched address/data/write-enable are presented to the memory
//   RESP   : rspN_valid pulses for the owning port; read data is forwarded
// so at most one operation completes every three cycles.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/wr/addr/wdata   requester N access request (N = 0, 1)
//   reqN_ready                 requester N accepted this cycle (combinational)
//   rspN_valid                 one-cycle completion pulse to requester N
//   rsp_rdata                  shared read data, zero unless a read completes
//   mem_wr_en/addr/wdata       memory command, driven only during ACCESS
//   mem_rdata                  memory read data, valid one cycle after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  // Requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,

  // Requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,

  // Responses
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,

  // Memory side
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Port that won the most recent acceptance; 1 out of reset so port 0 wins
  // the first tie.
  logic last_grant_q, last_grant_d;

  // Operation captured at acceptance. Requester inputs are ignored afterwards.
  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              port_q,  port_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic gnt_any;
  logic gnt_port;
  logic accept;

  always_comb begin
    gnt_any  = req0_valid | req1_valid;
    gnt_port = 1'b0;
    if (req0_valid && req1_valid) begin
      // Tie: the port that did not win last time goes first.
      gnt_port = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_port = 1'b1;
    end
  end

  // Valid is only looked at in IDLE, so a pulse that rises and falls while an
  // operation is in flight is never seen and issues nothing.
  assign accept = (state_q == StIdle) && gnt_any;

  // Selected requester fields, muxed by the grant.
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    if (gnt_port) begin
      sel_wr    = req1_wr;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end else begin
      sel_wr    = req0_wr;
      sel_addr  = req0_addr;
      sel_wdata = req0_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // State register (synchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      port_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      port_q       <= port_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    port_d       = port_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StAccess;
          last_grant_d = gnt_port;
          wr_d         = sel_wr;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          port_d       = gnt_port;
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_rdata  = '0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        req0_ready = accept & ~gnt_port;
        req1_ready = accept &  gnt_port;
      end
      StAccess: begin
        mem_wr_en = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      StResp: begin
        rsp0_valid = ~port_q;
        rsp1_valid =  port_q;
        // Writes complete with zero data; reads forward the memory's
        // registered output, which is valid in this cycle.
        if (!wr_q) begin
          rsp_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter with a behavioural synchronous memory behind it. Every
// acceptance pushes the expected response (port, data, cycle) onto a queue
// using a separate reference copy of the memory; every response pulse pops and
// compares it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req0_wr;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_wr;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_wr    (req1_wr),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory seen by the DUT, and the bench's reference copy.
  logic [DW-1:0] sim_mem [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   gcyc_q[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int acc0_cnt = 0;
  int rsp0_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Synchronous memory: registered read, write on mem_wr_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) sim_mem[mem_addr] <= mem_wdata;
    mem_rdata <= sim_mem[mem_addr];
  end

  task automatic note_accept(input int p, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    exp_t n;
    n.port = p;
    n.data = wr ? '0 : ref_mem[a];
    n.cyc  = cyc;
    exp_q.push_back(n);
    if (wr) ref_mem[a] = d;
    grant_q.push_back(p);
    gcyc_q.push_back(cyc);
    if (p == 0) acc0_cnt++;
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();  // anything in flight is aborted by reset
    end else begin
      check_eq("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (req0_ready) note_accept(0, req0_wr, req0_addr, req0_wdata);
      if (req1_ready) note_accept(1, req1_wr, req1_addr, req1_wdata);
      if (mem_wr_en) wr_cnt++;
      if (rsp0_valid || rsp1_valid) begin
        if (rsp0_valid) rsp0_cnt++;
        check_eq("rsp_onehot", {63'd0, rsp0_valid & rsp1_valid}, 64'd0);
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_port", rsp1_valid ? 64'd1 : 64'd0, 64'(e.port));
          check_eq("rsp_data", 64'(rsp_rdata), 64'(e.data));
          check_eq("rsp_latency", 64'(cyc), 64'(e.cyc + 2));
        end
      end else begin
        check_eq("rdata_idle", 64'(rsp_rdata), 64'd0);
      end
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit got = 0;
    if (p == 0) begin
      req0_wr = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
    end else begin
      req1_wr = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  // Hold both ports valid until n acceptances have been seen (bounded).
  task automatic tie_run(input int n);
    int cnt = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 20 * n && cnt < n; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) cnt++;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (cnt < n) check_eq("tie_timeout", 64'(cnt), 64'(n));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  int w0, a0, r0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = 32'hA5A5_0000 + 32'(i * 257);
      ref_mem[i] = 32'hA5A5_0000 + 32'(i * 257);
    end
    req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rsp0", {63'd0, rsp0_valid}, 64'd0);
    check_eq("rst_rsp1", {63'd0, rsp1_valid}, 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    check_eq("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    check_eq("rst_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready0", {63'd0, req0_ready}, 64'd0);
    check_eq("idle_ready1", {63'd0, req1_ready}, 64'd0);
    @(posedge clk);
    #1;

    // Continuous tie after reset: grants alternate 0,1,0,1, one per 3 cycles.
    grant_q.delete(); gcyc_q.delete();
    req0_addr = 8'h01; req1_addr = 8'h02;
    tie_run(4);
    drain();
    if (grant_q.size() < 4) begin
      check_eq("rr_count", 64'(grant_q.size()), 64'd4);
    end else begin
      for (int i = 0; i < 4; i++) check_eq("rr_grant", 64'(grant_q[i]), 64'(i % 2));
      for (int i = 1; i < 4; i++) check_eq("rr_spacing", 64'(gcyc_q[i] - gcyc_q[i-1]), 64'd3);
    end

    // Port 0 write then read back.
    w0 = wr_cnt;
    issue(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
    drain();
    check_eq("wr_en_cycles_p0", 64'(wr_cnt - w0), 64'd1);
    issue(0, 1'b0, 8'h10, '0);
    drain();

    // Boundary address: port 1 write, port 0 read.
    w0 = wr_cnt;
    issue(1, 1'b1, 8'hFF, 32'h1234_5678);
    drain();
    check_eq("wr_en_cycles_p1", 64'(wr_cnt - w0), 64'd1);
    issue(0, 1'b0, 8'hFF, '0);
    drain();
    issue(0, 1'b1, 8'h00, 32'h0BAD_F00D);
    drain();
    issue(1, 1'b0, 8'h00, '0);
    drain();

    // Port 0 valid pulsed only during RESP of a port 1 read: ignored.
    issue(1, 1'b0, 8'h20, '0);
    a0 = acc0_cnt; r0 = rsp0_cnt; w0 = wr_cnt;
    @(posedge clk);
    #1;
    req0_wr = 1'b1; req0_addr = 8'h30; req0_wdata = 32'hFFFF_FFFF; req0_valid = 1'b1;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drain();
    check_eq("pulse_no_accept", 64'(acc0_cnt - a0), 64'd0);
    check_eq("pulse_no_rsp", 64'(rsp0_cnt - r0), 64'd0);
    check_eq("pulse_no_write", 64'(wr_cnt - w0), 64'd0);
    check_eq("pulse_mem", 64'(sim_mem[8'h30]), 64'(ref_mem[8'h30]));

    // Random single-port traffic.
    for (int k = 0; k < 10; k++) begin
      issue(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 8'($urandom), $urandom);
      drain();
    end

    // Reset during ACCESS of a port 0 read aborts it; next tie goes to port 0.
    issue(0, 1'b0, 8'h05, '0);
    r0 = rsp0_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_rsp", 64'(rsp0_cnt - r0), 64'd0);
    check_eq("abort_wr_en", {63'd0, mem_wr_en}, 64'd0);
    @(posedge clk);
    #1;
    grant_q.delete(); gcyc_q.delete();
    req0_wr = 1'b0; req1_wr = 1'b0; req0_addr = 8'h07; req1_addr = 8'h08;
    tie_run(1);
    drain();
    if (grant_q.size() < 1) check_eq("abort_tie_count", 64'd0, 64'd1);
    else check_eq("abort_tie_grant", 64'(grant_q[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, memory address width (256 words).
REQ-002 Parameter: DATA_W, 32, memory word width.
REQ-003 Port: clk  input  1  single clock, all state updates on posedge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: req0_valid, req1_valid  input  1 each  requester n has a pending access.
REQ-006 Port: req0_ready, req1_ready  output  1 each  requester n's access accepted this cycle (combinational).
REQ-007 Port: req0_wr, req1_wr  input  1 each  1 = write, 0 = read.
REQ-008 Port: req0_addr, req1_addr  input  ADDR_W each  word address.
REQ-009 Port: req0_wdata, req1_wdata  input  DATA_W each  write data.
REQ-010 Port: rsp0_valid, rsp1_valid  output  1 each  one-cycle completion pulse to requester n.
REQ-011 Port: rsp_rdata  output  DATA_W  read data, shared, qualified by rspN_valid.
REQ-012 Port: mem_wr_en  output  1  to memory write enable.
REQ-013 Port: mem_addr  output  ADDR_W  to memory address.
REQ-014 Port: mem_wdata  output  DATA_W  to memory write data.
REQ-015 Port: mem_rdata  input  DATA_W  from memory registered read data, valid one cycle after a non-write address cycle.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 Acceptance: reqN_ready SHALL be asserted only in IDLE, only for the granted port, only when that port's valid is high; at most one ready high per cycle.
REQ-018 Arbitration SHALL be round-robin: single valid wins; both valid -> port not granted last wins; last_grant updates on acceptance only.
REQ-019 On acceptance, wr, addr, wdata and port id SHALL be latched into internal registers; requester inputs ignored until IDLE again.
REQ-020 In ACCESS, mem_addr/mem_wdata SHALL equal the latched values and mem_wr_en SHALL equal latched wr; outside ACCESS mem_wr_en SHALL be 0.
REQ-021 In RESP, rspN_valid SHALL be 1 for exactly one cycle, for the latched port only; rsp_rdata SHALL equal mem_rdata for reads and 0 for writes.
REQ-022 When no response pulses, rsp_rdata SHALL be 0.
REQ-023 Latency: acceptance at cycle T -> memory access at T+1 -> rspN_valid at T+2 -> next acceptance earliest at T+3 (one op per 3 cycles).
REQ-024 Responses SHALL NOT be back-pressured; requester must sample rspN_valid when asserted.
REQ-025 Requester holding valid with ready low SHALL keep wr/addr/wdata stable; arbiter SHALL not depend on this beyond the acceptance cycle.
REQ-026 Address SHALL be used unmodified; full range 0..2^ADDR_W-1 legal, no wrap or bounds check.
REQ-027 Valid deasserted before acceptance SHALL be treated as withdrawn; no access issued.

Reset
REQ-028 While rst_n = 0 at posedge: state=IDLE, last_grant=port 1 (so port 0 wins first tie), latched registers=0.
REQ-029 Outputs during/after reset: reqN_ready derived from IDLE, rspN_valid=0, rsp_rdata=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted in ACCESS or RESP SHALL abort the operation: no rsp pulse, mem_wr_en=0 from the next cycle; a write already presented in ACCESS at the reset edge may complete in memory.

Verification
REQ-031 Port 0 write addr 0x10 data 0xDEADBEEF, later port 0 read 0x10 -> rsp0_valid at T+2 with rsp_rdata 0xDEADBEEF; rsp1_valid stays 0.
REQ-032 Both ports valid continuously after reset, reads of 0x01/0x02 -> grants alternate 0,1,0,1 with one acceptance every 3 cycles.
REQ-033 Port 1 write 0xFF data 0x12345678 then port 0 read 0xFF -> rsp0 returns 0x12345678 (boundary address).
REQ-034 Port 0 valid pulsed one cycle while arbiter in RESP -> no ready, no memory access, no response.
REQ-035 rst_n low during ACCESS of a read -> no rsp pulse, state IDLE, next tie grants port 0.
REQ-036 Write response -> rsp1_valid one cycle, rsp_rdata 0x00000000; mem_wr_en high exactly one cycle.
